// File: rtl/opdrv_pkg.sv
// Shared types and default widths for the operand_driver sequencer.
package opdrv_pkg;

    localparam int DW_DEF  = 12;
    localparam int YW_DEF  = 40;
    localparam int LAT_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_END   = 2'd3
    } state_e;

    typedef struct packed {
        logic [DW_DEF-1:0] a;
        logic [DW_DEF-1:0] b;
        logic [DW_DEF-1:0] c;
    } slot_t;

endpackage

// File: rtl/opdrv_slot_ram.sv
// DEPTH x W operand register file: async-reset clear, one write port, one combinational read port.
module opdrv_slot_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/operand_driver.sv
// Drives programmed operand sets onto module_top, captures y LAT cycles later and accumulates a checksum.
//   state    | meaning
//   ST_IDLE  | waiting for start; slot writes accepted
//   ST_DRIVE | one cycle, e=1 with slot[idx] on a/b/c
//   ST_WAIT  | LAT cycles, result captured when wait counter hits 0
//   ST_END   | one cycle, done=1, back to idle
module operand_driver
    import opdrv_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int YW    = YW_DEF,
    parameter int DEPTH = 8,
    parameter int LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_a,
    input  logic [DW-1:0]            wr_b,
    input  logic [DW-1:0]            wr_c,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic                     start,
    output logic [DW-1:0]            a,
    output logic [DW-1:0]            b,
    output logic [DW-1:0]            c,
    output logic                     e,
    input  logic [YW-1:0]            y,
    output logic                     busy,
    output logic                     res_valid,
    output logic [YW-1:0]            res_data,
    output logic [YW-1:0]            checksum,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = 3 * DW;

    state_e          state_q, state_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   n_q, n_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic            res_valid_q, res_valid_d;
    logic [YW-1:0]   res_data_q, res_data_d;
    logic [YW-1:0]   checksum_q, checksum_d;

    logic            ram_we;
    logic [AW-1:0]   rd_addr;
    logic [SW-1:0]   rd_data;
    logic [SW-1:0]   ld_slot;
    logic [CW-1:0]   idx_inc;
    logic [CW-1:0]   n_start;

    assign busy    = (state_q == ST_DRIVE) || (state_q == ST_WAIT);
    assign e       = (state_q == ST_DRIVE);
    assign done    = (state_q == ST_END);
    assign ram_we  = wr_en && !busy;
    assign idx_inc = idx_q + CW'(1);
    assign n_start = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;

    // The next slot is read one edge ahead so a/b/c are registered when DRIVE begins.
    assign rd_addr = (state_q == ST_WAIT) ? idx_inc[AW-1:0] : '0;

    // A write landing on slot 0 in the start cycle must be seen by the first DRIVE.
    always_comb begin
        ld_slot = rd_data;
        if (state_q == ST_IDLE && ram_we && wr_addr == '0) begin
            ld_slot = {wr_a, wr_b, wr_c};
        end
    end

    opdrv_slot_ram #(
        .DEPTH (DEPTH),
        .W     (SW)
    ) u_slot_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data ({wr_a, wr_b, wr_c}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        wcnt_d      = wcnt_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        checksum_d  = checksum_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d        = n_start;
                    idx_d      = '0;
                    checksum_d = '0;
                    if (n_start == '0) begin
                        state_d = ST_END;
                    end else begin
                        state_d           = ST_DRIVE;
                        {a_d, b_d, c_d}   = ld_slot;
                    end
                end
            end
            ST_DRIVE: begin
                wcnt_d  = 4'(LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    res_valid_d = 1'b1;
                    res_data_d  = y;
                    checksum_d  = checksum_q + y;
                    idx_d       = idx_inc;
                    if (idx_inc < n_q) begin
                        state_d         = ST_DRIVE;
                        {a_d, b_d, c_d} = ld_slot;
                    end else begin
                        state_d = ST_END;
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            wcnt_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            checksum_q  <= checksum_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_operand_driver.sv
// Directed bench for operand_driver with a registered a*b*c stand-in for module_top.
module tb_operand_driver;
    import opdrv_pkg::*;

    localparam int DW    = 12;
    localparam int YW    = 40;
    localparam int DEPTH = 8;
    localparam int LAT   = 2;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_a, wr_b, wr_c;
    logic [AW:0]   count;
    logic          start;
    logic [DW-1:0] a, b, c;
    logic          e;
    logic [YW-1:0] y;
    logic          busy, res_valid, done;
    logic [YW-1:0] res_data, checksum;

    logic [YW-1:0] p1_q;
    logic          force_ones;

    typedef struct {
        int            cyc;
        logic [YW-1:0] data;
    } exp_t;

    exp_t  sb[$];
    slot_t mdl[DEPTH];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    // module_top stand-in: y valid LAT=2 cycles after the e-strobe cycle
    always_ff @(posedge clk) begin
        p1_q <= YW'(a) * YW'(b) * YW'(c);
        y    <= force_ones ? '1 : p1_q;
    end

    operand_driver #(.DW(DW), .YW(YW), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .wr_c      (wr_c),
        .count     (count),
        .start     (start),
        .a         (a),
        .b         (b),
        .c         (c),
        .e         (e),
        .y         (y),
        .busy      (busy),
        .res_valid (res_valid),
        .res_data  (res_data),
        .checksum  (checksum),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic write_slot(input int addr, input logic [DW-1:0] va, input logic [DW-1:0] vb,
                              input logic [DW-1:0] vc);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_a    = va;
        wr_b    = vb;
        wr_c    = vc;
        mdl[addr] = '{a: va, b: vb, c: vc};
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Called at a negedge in IDLE; the following posedge is the start edge (cycle 0).
    task automatic run(input int cnt, input int exp_n, input bit poke);
        int            cyc;
        int            strobes;
        bit            got_done;
        logic [YW-1:0] sum;
        logic [YW-1:0] d;
        exp_t          x;
        sum = '0;
        for (int k = 0; k < exp_n; k++) begin
            d = force_ones ? '1 : YW'(mdl[k].a) * YW'(mdl[k].b) * YW'(mdl[k].c);
            sum = sum + d;
            sb.push_back('{cyc: 1 + (k + 1) * (LAT + 1), data: d});
        end
        count = (AW+1)'(cnt);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wr_en    = 1'b0;
        cyc      = 1;
        strobes  = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            if (e) begin
                chk("e_cycle", 64'(cyc), 64'(1 + strobes * (LAT + 1)));
                if (strobes < DEPTH) begin
                    chk("drv_a", 64'(a), 64'(mdl[strobes].a));
                    chk("drv_b", 64'(b), 64'(mdl[strobes].b));
                    chk("drv_c", 64'(c), 64'(mdl[strobes].c));
                end
                strobes++;
            end
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("res_unexpected", 64'(res_valid), 64'(0));
                end else begin
                    x = sb.pop_front();
                    chk("res_cycle", 64'(cyc), 64'(x.cyc));
                    chk("res_data", 64'(res_data), 64'(x.data));
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_cycle", 64'(cyc), 64'(exp_n == 0 ? 1 : 1 + exp_n * (LAT + 1)));
                chk("checksum", 64'(checksum), 64'(sum));
                chk("strobes", 64'(strobes), 64'(exp_n));
                chk("sb_empty", 64'(sb.size()), 64'(0));
                chk("busy_at_done", 64'(busy), 64'(0));
            end else begin
                if (poke && cyc == 2) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wr_a    = 12'hABC;
                    wr_b    = 12'hDEF;
                    wr_c    = 12'h123;
                    start   = 1'b1;
                    count   = 4'd1;
                end else begin
                    wr_en = 1'b0;
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!got_done) chk("done_timeout", 64'(done), 64'(1));
        sb.delete();
        @(negedge clk);
        chk("busy_after", 64'(busy), 64'(0));
        chk("e_after", 64'(e), 64'(0));
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_a       = '0;
        wr_b       = '0;
        wr_c       = '0;
        count      = '0;
        start      = 1'b0;
        force_ones = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        @(negedge clk);
        chk("rst_a", 64'(a), 64'(0));
        chk("rst_e", 64'(e), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_data", 64'(res_data), 64'(0));
        chk("rst_checksum", 64'(checksum), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // single slot, then two slots
        write_slot(0, 12'h76C, 12'h020, 12'h0A5);
        run(1, 1, 1'b0);
        write_slot(1, 12'h001, 12'h001, 12'h0FF);
        run(2, 2, 1'b0);
        chk("cks_two_slots", 64'(checksum), 64'h99147F);

        // checksum wraparound
        force_ones = 1'b1;
        run(2, 2, 1'b0);
        chk("cks_wrap", 64'(checksum), 64'hFF_FFFF_FFFE);
        force_ones = 1'b0;

        // count boundaries
        run(0, 0, 1'b0);
        run(9, 8, 1'b0);

        // writes and start during busy are ignored
        run(2, 2, 1'b0);
        run(2, 2, 1'b1);
        run(1, 1, 1'b0);

        // write and start in the same idle cycle
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_a    = 12'h00F;
        wr_b    = 12'h010;
        wr_c    = 12'h003;
        mdl[0]  = '{a: 12'h00F, b: 12'h010, c: 12'h003};
        run(1, 1, 1'b0);

        // reset during WAIT of slot 1
        write_slot(1, 12'h005, 12'h006, 12'h007);
        count = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_a", 64'(a), 64'(0));
        chk("mid_rst_b", 64'(b), 64'(0));
        chk("mid_rst_c", 64'(c), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_res_data", 64'(res_data), 64'(0));
        chk("mid_rst_checksum", 64'(checksum), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", 64'(done), 64'(0));
            chk("post_rst_res_valid", 64'(res_valid), 64'(0));
        end
        run(8, 8, 1'b0);
        write_slot(0, 12'h76C, 12'h020, 12'h0A5);
        run(1, 1, 1'b0);
        chk("cks_after_rst", 64'(checksum), 64'h991380);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
